// File: rtl/led_pwm_sequencer.sv
// Multi-channel LED PWM engine: off/solid/blink/breathe per channel, boundary-committed config.
// Define LED_PWM_GAMMA_EN to square the compared duty (perceptual gamma); default is linear.
module led_pwm_sequencer #(
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned LOG2DELAY = 21,
    localparam int unsigned CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_level,
    output logic                cfg_err,
    output logic                tick,
    output logic [CHANNELS-1:0] pwm_out
);

    typedef enum logic [1:0] {
        ModeOff     = 2'd0,
        ModeSolid   = 2'd1,
        ModeBlink   = 2'd2,
        ModeBreathe = 2'd3
    } mode_e;

    logic [PWM_BITS-1:0]  pwm_cnt_q;
    logic [LOG2DELAY-1:0] presc_q;
    logic [CHANNELS-1:0]  pwm_q;
    logic                 cfg_err_q, cfg_err_d;

    logic                 shadow_valid_q, shadow_valid_d;
    logic [CHAN_W-1:0]    shadow_chan_q, shadow_chan_d;
    mode_e                shadow_mode_q, shadow_mode_d;
    logic [PWM_BITS-1:0]  shadow_level_q, shadow_level_d;

    mode_e                mode_q  [CHANNELS];
    mode_e                mode_d  [CHANNELS];
    logic [PWM_BITS-1:0]  level_q [CHANNELS];
    logic [PWM_BITS-1:0]  level_d [CHANNELS];
    logic [PWM_BITS-1:0]  ramp_q  [CHANNELS];
    logic [PWM_BITS-1:0]  ramp_d  [CHANNELS];
    logic [CHANNELS-1:0]  dir_down_q, dir_down_d;
    logic [CHANNELS-1:0]  phase_q, phase_d;

    logic [PWM_BITS-1:0]  duty     [CHANNELS];
    logic [PWM_BITS-1:0]  cmp_duty [CHANNELS];

    logic boundary;
    logic accept;
    logic chan_ok;

    assign boundary  = &pwm_cnt_q;
    assign tick      = &presc_q;
    assign cfg_ready = ~shadow_valid_q;
    assign cfg_err   = cfg_err_q;
    assign pwm_out   = pwm_q;
    assign accept    = cfg_valid & cfg_ready;
    assign chan_ok   = 32'(cfg_chan) < CHANNELS;

    // Shadow register: holds one accepted write until the next period boundary.
    always_comb begin
        shadow_valid_d = shadow_valid_q;
        shadow_chan_d  = shadow_chan_q;
        shadow_mode_d  = shadow_mode_q;
        shadow_level_d = shadow_level_q;
        cfg_err_d      = 1'b0;
        if (boundary && shadow_valid_q) begin
            shadow_valid_d = 1'b0;
        end
        if (accept) begin
            if (chan_ok) begin
                shadow_valid_d = 1'b1;
                shadow_chan_d  = cfg_chan;
                shadow_mode_d  = mode_e'(cfg_mode);
                shadow_level_d = cfg_level;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        logic [PWM_BITS-1:0] ramp_n;
        dir_down_d = dir_down_q;
        phase_d    = phase_q;
        for (int c = 0; c < CHANNELS; c++) begin
            ramp_n     = ramp_q[c];
            mode_d[c]  = mode_q[c];
            level_d[c] = level_q[c];
            ramp_d[c]  = ramp_q[c];
            // A commit overrides any animation step landing in the same cycle.
            if (boundary && shadow_valid_q && int'(shadow_chan_q) == c) begin
                mode_d[c]     = shadow_mode_q;
                level_d[c]    = shadow_level_q;
                ramp_d[c]     = '0;
                dir_down_d[c] = 1'b0;
                phase_d[c]    = 1'b1;
            end else if (tick) begin
                unique case (mode_q[c])
                    ModeBlink: phase_d[c] = ~phase_q[c];
                    ModeBreathe: begin
                        if (!dir_down_q[c]) begin
                            ramp_n = (ramp_q[c] < level_q[c]) ? ramp_q[c] + 1'b1 : ramp_q[c];
                            if (ramp_n >= level_q[c]) dir_down_d[c] = 1'b1;
                        end else begin
                            ramp_n = (ramp_q[c] != '0) ? ramp_q[c] - 1'b1 : ramp_q[c];
                            if (ramp_n == '0) dir_down_d[c] = 1'b0;
                        end
                        ramp_d[c] = ramp_n;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
`ifdef LED_PWM_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = '0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            duty[c] = '0;
            unique case (mode_q[c])
                ModeOff:     duty[c] = '0;
                ModeSolid:   duty[c] = level_q[c];
                ModeBlink:   duty[c] = phase_q[c] ? level_q[c] : '0;
                ModeBreathe: duty[c] = ramp_q[c];
                default:     duty[c] = '0;
            endcase
`ifdef LED_PWM_GAMMA_EN
            sq = {{PWM_BITS{1'b0}}, duty[c]} * {{PWM_BITS{1'b0}}, duty[c]};
            cmp_duty[c] = sq[2*PWM_BITS-1:PWM_BITS];
            // Keep dim settings visible rather than rounding them to off.
            if (duty[c] != '0 && cmp_duty[c] == '0) begin
                cmp_duty[c]    = '0;
                cmp_duty[c][0] = 1'b1;
            end
`else
            cmp_duty[c] = duty[c];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q      <= '0;
            presc_q        <= '0;
            pwm_q          <= '0;
            cfg_err_q      <= 1'b0;
            shadow_valid_q <= 1'b0;
            shadow_chan_q  <= '0;
            shadow_mode_q  <= ModeOff;
            shadow_level_q <= '0;
            dir_down_q     <= '0;
            phase_q        <= '1;
            for (int c = 0; c < CHANNELS; c++) begin
                mode_q[c]  <= ModeOff;
                level_q[c] <= '0;
                ramp_q[c]  <= '0;
            end
        end else begin
            pwm_cnt_q      <= pwm_cnt_q + 1'b1;
            presc_q        <= presc_q + 1'b1;
            cfg_err_q      <= cfg_err_d;
            shadow_valid_q <= shadow_valid_d;
            shadow_chan_q  <= shadow_chan_d;
            shadow_mode_q  <= shadow_mode_d;
            shadow_level_q <= shadow_level_d;
            dir_down_q     <= dir_down_d;
            phase_q        <= phase_d;
            for (int c = 0; c < CHANNELS; c++) begin
                mode_q[c]  <= mode_d[c];
                level_q[c] <= level_d[c];
                ramp_q[c]  <= ramp_d[c];
                pwm_q[c]   <= enable & (cmp_duty[c] > pwm_cnt_q);
            end
        end
    end

endmodule
